// File: rtl/datagen_pkg.sv
// Shared types and default widths for the test-pattern burst sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package datagen_pkg;

  localparam int DATAGEN_DATA_W = 6;
  localparam int DATAGEN_LEN_W  = 8;
  localparam int DATAGEN_GAP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/datagen_ctrl_if.sv
// Valid/ready pattern stream from the burst sequencer toward the host-transfer path.
// Latency: n/a (wires only).
// Backpressure: sink holds out_ready low; source keeps out_data/out_last stable.
// Ports: out_data/out_valid/out_last (master drives), out_ready (slave drives).
interface datagen_ctrl_if
  import datagen_pkg::*;
#(
  parameter int DATA_W = DATAGEN_DATA_W
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/datagen_ctrl_pattern_cnt.sv
// Wrapping pattern counter with synchronous load and count enable.
// Latency: load/increment visible one cycle after the enabling edge.
// Backpressure: none; the owner gates en with the stream transfer.
// Ports: clk, rst (async active-low), load/load_val, en, q.
module pattern_cnt #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              en,
  output logic [DATA_W-1:0] q
);

  // Load wins over count so a back-to-back burst restarts cleanly on the
  // same edge that retires the previous last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q + DATA_W'(1);
    end
  end

endmodule

// File: rtl/datagen_ctrl.sv
// Burst sequencer: runs a wrapping pattern counter in bounded bursts from a seed.
// Latency: start sampled at edge N gives out_valid with out_data=seed after edge N; 1 word/cycle.
// Backpressure: out_ready low holds out_data/out_last; all outputs registered (no ready->valid path).
// Ports: clk, rst (async active-low), start/stop, burst_len/gap_len/seed config,
//        dout (stream master: out_data/out_valid/out_ready/out_last), busy, done.
// Build option: DATAGEN_CTRL_REPEAT_EN adds the GAP state and automatic repeat.
module datagen_ctrl
  import datagen_pkg::*;
#(
  parameter int DATA_W = DATAGEN_DATA_W,
  parameter int LEN_W  = DATAGEN_LEN_W,
  parameter int GAP_W  = DATAGEN_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [DATA_W-1:0] seed,
  datagen_ctrl_if.master   dout,
  output logic             busy,
  output logic             done
);

  state_t            state, state_nxt;
  logic              stop_pending, stop_pending_nxt;
  logic [LEN_W-1:0]  word_cnt, word_cnt_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_nxt;
  logic              latch_cfg;
  logic              cnt_load;
  logic [DATA_W-1:0] cnt_load_val;
  logic [DATA_W-1:0] cnt_q;
  logic              xfer;
  logic              done_nxt;
  logic              valid_q, last_q;
  logic              last_nxt;

`ifdef DATAGEN_CTRL_REPEAT_EN
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic [DATA_W-1:0] seed_q;
`else
  // gap_len has no function without repeat mode.
  logic unused_gap;
  assign unused_gap = ^gap_len;
`endif

  assign xfer = valid_q && dout.out_ready;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt        = state;
    stop_pending_nxt = stop_pending;
    word_cnt_nxt     = word_cnt;
    latch_cfg        = 1'b0;
    cnt_load         = 1'b0;
    done_nxt         = 1'b0;
`ifdef DATAGEN_CTRL_REPEAT_EN
    gap_cnt_nxt      = gap_cnt;
    cnt_load_val     = (state == ST_IDLE) ? seed : seed_q;
`else
    cnt_load_val     = seed;
`endif

    case (state)
      ST_IDLE: begin
        if (start && !stop && (burst_len != '0)) begin
          state_nxt    = ST_RUN;
          latch_cfg    = 1'b1;
          cnt_load     = 1'b1;
          word_cnt_nxt = '0;
        end
      end

      ST_RUN: begin
        if (stop) begin
          stop_pending_nxt = 1'b1;
        end
        if (xfer) begin
          if (word_cnt == len_q - LEN_W'(1)) begin
            done_nxt = 1'b1;
`ifdef DATAGEN_CTRL_REPEAT_EN
            // A stop seen on the final transfer cycle counts as pending.
            if (stop_pending || stop) begin
              state_nxt        = ST_IDLE;
              stop_pending_nxt = 1'b0;
            end else if (gap_q == '0) begin
              state_nxt    = ST_RUN;
              cnt_load     = 1'b1;
              word_cnt_nxt = '0;
            end else begin
              state_nxt   = ST_GAP;
              gap_cnt_nxt = gap_q;
            end
`else
            state_nxt        = ST_IDLE;
            stop_pending_nxt = 1'b0;
`endif
          end else begin
            word_cnt_nxt = word_cnt + LEN_W'(1);
          end
        end
      end

`ifdef DATAGEN_CTRL_REPEAT_EN
      ST_GAP: begin
        // gap_cnt counts remaining idle cycles including the current one.
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_nxt    = ST_RUN;
          cnt_load     = 1'b1;
          word_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
`endif

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    len_nxt  = latch_cfg ? burst_len : len_q;
    last_nxt = (state_nxt == ST_RUN) && (word_cnt_nxt == len_nxt - LEN_W'(1));
  end

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      stop_pending <= 1'b0;
      word_cnt     <= '0;
      len_q        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      stop_pending <= stop_pending_nxt;
      word_cnt     <= word_cnt_nxt;
      valid_q      <= (state_nxt == ST_RUN);
      last_q       <= last_nxt;
      busy         <= (state_nxt != ST_IDLE);
      done         <= done_nxt;
      if (latch_cfg) begin
        len_q <= burst_len;
      end
    end
  end

`ifdef DATAGEN_CTRL_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q   <= '0;
      gap_cnt <= '0;
      seed_q  <= '0;
    end else begin
      gap_cnt <= gap_cnt_nxt;
      if (latch_cfg) begin
        gap_q  <= gap_len;
        seed_q <= seed;
      end
    end
  end
`endif

  pattern_cnt #(
    .DATA_W (DATA_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (xfer),
    .q        (cnt_q)
  );

  assign dout.out_data  = cnt_q;
  assign dout.out_valid = valid_q;
  assign dout.out_last  = last_q;

endmodule

// File: tb/tb_datagen_ctrl.sv
// Testbench for datagen_ctrl: directed scenarios plus randomized bursts.
// Latency: n/a.
// Backpressure: out_ready driven always-high, alternating or random.
module tb_datagen_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic [7:0] gap_len = 8'd0;
  logic [5:0] seed = 6'd0;
  logic       busy, done;

  datagen_ctrl_if #(.DATA_W(6)) dif ();

  datagen_ctrl #(.DATA_W(6), .LEN_W(8), .GAP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .gap_len   (gap_len),
    .seed      (seed),
    .dout      (dif),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;   // 0: always ready, 1: alternate starting high, 2: random
  int alt_phase = 0;
  bit cmp_en = 1'b0;
  int got[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    case (rdy_mode)
      0: dif.out_ready = 1'b1;
      1: begin dif.out_ready = (alt_phase % 2 == 0); alt_phase++; end
      default: dif.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Behavioural reference: a burst is "word m_idx of m_len starting at m_seed";
  // between repeated bursts m_gap_left idle cycles remain.
  int m_active, m_idx, m_len, m_seed, m_gap, m_gap_left, m_sp, m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_idx = 0; m_len = 0; m_seed = 0; m_gap = 0;
      m_gap_left = 0; m_sp = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_active != 0) begin
        if (stop) m_sp = 1;
        if (dif.out_ready) begin
          if (m_idx == m_len - 1) begin
            m_done = 1;
`ifdef DATAGEN_CTRL_REPEAT_EN
            if (m_sp != 0) begin m_active = 0; m_sp = 0; end
            else if (m_gap == 0) m_idx = 0;
            else begin m_active = 0; m_gap_left = m_gap; end
`else
            m_active = 0; m_sp = 0;
`endif
          end else begin
            m_idx++;
          end
        end
      end else if (m_gap_left > 0) begin
        if (stop) m_gap_left = 0;
        else begin
          m_gap_left--;
          if (m_gap_left == 0) begin m_active = 1; m_idx = 0; end
        end
      end else if (start && !stop && burst_len != 0) begin
        m_active = 1; m_idx = 0; m_len = burst_len; m_seed = seed; m_gap = gap_len;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("valid", dif.out_valid, m_active);
      chk("busy", busy, (m_active != 0 || m_gap_left > 0) ? 1 : 0);
      chk("done", done, m_done);
      if (m_active != 0) begin
        chk("data", dif.out_data, (m_seed + m_idx) % 64);
        chk("last", dif.out_last, (m_idx == m_len - 1) ? 1 : 0);
      end
    end
  end

  always @(posedge clk) begin
    if (rst && dif.out_valid && dif.out_ready) got.push_back(int'(dif.out_data));
  end

  task automatic launch(input int s, input int l, input int g);
    seed = 6'(s); burst_len = 8'(l); gap_len = 8'(g);
    start = 1'b1; alt_phase = 0;
    step();
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_data"}, dif.out_data, 0);
    chk({nm, "_valid"}, dif.out_valid, 0);
    chk({nm, "_last"}, dif.out_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  int wrap_exp[8] = '{60, 61, 62, 63, 0, 1, 2, 3};
  int rep_valid[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
  int rep_data[10]  = '{5, 6, 7, 0, 0, 5, 6, 7, 0, 0};
  int rep_done[10]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

  initial begin
    dif.out_ready = 1'b1;
    step(); step();
    check_outputs_zero("reset");
    rst = 1'b1;
    step();
    cmp_en = 1'b1;

    // Wrap at 63 -> 0, last on word 3, done one cycle later.
    rdy_mode = 0;
    launch(60, 8, 0);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_data", dif.out_data, wrap_exp[i]);
      chk("wrap_last", dif.out_last, (i == 7) ? 1 : 0);
      stop = (i == 1);
      step();
    end
    stop = 1'b0;
    chk("wrap_done", done, 1);
    chk("wrap_busy", busy, 0);
    step();
    chk("wrap_done_once", done, 0);

    // Alternating backpressure: 4 words in 8 cycles, data holds while stalled.
    rdy_mode = 1;
    got.delete();
    launch(0, 4, 0);
    for (int i = 0; i < 7; i++) begin
      stop = (i == 1);
      step();
    end
    stop = 1'b0;
    chk("bp_done", done, 1);
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk("bp_word", got[i], i);
    rdy_mode = 0;
    step();

    // Zero length and start+stop are both rejected in IDLE.
    launch(3, 0, 0);
    step();
    chk("len0_busy", busy, 0);
    chk("len0_valid", dif.out_valid, 0);
    stop = 1'b1;
    launch(3, 3, 0);
    stop = 1'b0;
    step();
    chk("startstop_busy", busy, 0);

    // Start during RUN is ignored; the new seed applies at the next IDLE start.
    got.delete();
    launch(1, 4, 0);
    seed = 6'd9; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("ign_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk("ign_word", got[i], i + 1);
    chk("ign_busy", busy, 0);
    launch(9, 1, 0);
    chk("ign_newseed", dif.out_data, 9);
    step();

`ifdef DATAGEN_CTRL_REPEAT_EN
    // Repeat with a 2-cycle gap, then stop mid-burst, then stop in GAP.
    launch(5, 3, 2);
    for (int i = 0; i < 10; i++) begin
      chk("rep_valid", dif.out_valid, rep_valid[i]);
      if (rep_valid[i] != 0) chk("rep_data", dif.out_data, rep_data[i]);
      chk("rep_done", done, rep_done[i]);
      step();
    end
    chk("rep3_data0", dif.out_data, 5);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("rep3_last", dif.out_last, 1);
    step();
    chk("rep_stop_done", done, 1);
    chk("rep_stop_busy", busy, 0);
    step();
    launch(5, 3, 2);
    step(); step(); step();
    chk("gap_done", done, 1);
    chk("gap_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("gapstop_busy", busy, 0);
    chk("gapstop_done", done, 0);
    step();
`endif

    // Async reset mid-burst at word 3 of 8.
    launch(10, 8, 0);
    step(); step(); step();
    chk("arst_pre_data", dif.out_data, 13);
    #2 rst = 1'b0;
    #1 check_outputs_zero("arst");
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_valid", dif.out_valid, 0);

    // Randomized bursts, random backpressure, stray start/stop.
    rdy_mode = 2;
    for (int it = 0; it < 40; it++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        stop = ($urandom_range(0, 1) == 1);
        step();
      end
      stop = ($urandom_range(0, 7) == 0);
      launch($urandom_range(0, 63), $urandom_range(0, 6), $urandom_range(0, 3));
      stop = 1'b0;
      for (int c = 0; c < 300 && (m_active != 0 || m_gap_left > 0); c++) begin
        stop = (c > 12) || ($urandom_range(0, 19) == 0);
        start = ($urandom_range(0, 9) == 0);
        seed = 6'($urandom);
        burst_len = 8'($urandom_range(0, 6));
        gap_len = 8'($urandom_range(0, 3));
        step();
      end
      start = 1'b0; stop = 1'b0;
      if (m_active != 0 || m_gap_left > 0) chk("rand_timeout", 1, 0);
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datagen_ctrl.md
# datagen_ctrl

Burst sequencer for the test-pattern datapath. It owns a wrapping pattern counter and runs it in bounded bursts from a programmable seed. Each word goes out on a valid/ready stream toward the host-transfer path, with an optional inter-burst gap and automatic repeat. Software-facing control (start/stop, lengths, seed) arrives as registered config from the core register block.

## Interface
- `DATA_W`, 6: pattern word width.
- `LEN_W`, 8: width of burst length field, in words.
- `GAP_W`, 8: width of inter-burst gap field, in cycles.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low (asserted at 0).
- `start` in 1: begin a burst; sampled in IDLE only.
- `stop` in 1: request end of the sequence.
- `burst_len` in LEN_W: words per burst; 0 = invalid, start ignored.
- `gap_len` in GAP_W: idle cycles between repeated bursts.
- `seed` in DATA_W: first word of every burst.
- `out_data` out DATA_W: pattern word.
- `out_valid` out 1: word valid.
- `out_ready` in 1: sink accepts the word.
- `out_last` out 1: final word of the burst, qualified by out_valid.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse after each burst completes.

## Operation
- States: IDLE, RUN, GAP.
- IDLE: `start`=1, `stop`=0 and `burst_len`≠0 moves to RUN. On that transition, latch `burst_len`, `gap_len` and `seed`, load the counter with `seed`, and clear the word count.
- IDLE with `start` and `stop` both high: stop wins, stay IDLE.
- RUN: `out_valid`=1. A transfer is `out_valid && out_ready`. Each transfer increments `out_data` modulo 2^DATA_W (63→0) and the word count.
- `out_last`=1 when word count = latched len−1.
- The transfer of the last word ends the burst and pulses `done` on the next cycle.
- After a burst ends, the next state is IDLE. With repeat enabled and no pending stop, the next state is GAP, or RUN directly if latched gap = 0.
- Entering RUN from GAP reloads the counter from the latched seed.
- `stop` during RUN sets `stop_pending`. The burst still completes; it is never truncated, so valid never drops before a transfer. The burst then goes to IDLE.
- `stop` during GAP goes to IDLE on the next cycle, with no `done`.
- `start` outside IDLE is ignored. `stop` in IDLE is ignored.
- Config inputs change only take effect at the next IDLE→RUN transition.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0; state IDLE, `stop_pending`=0. Reset applies immediately, including mid-burst.
- Start latency: `start` sampled at edge N gives `out_valid`=1 with `out_data`=seed after edge N.
- Full throughput: with `out_ready`=1, one word per cycle and a burst of L words takes L cycles.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- `done` is high for exactly the cycle after the last transfer. `busy` is 0 in that cycle if the next state is IDLE.
- GAP lasts exactly the latched gap cycles with `out_valid`=0.
- Outputs are all registered; no combinational path from `out_ready` to `out_valid`.

## Configuration
- `DATAGEN_CTRL_REPEAT_EN` defined: repeat mode and the GAP state are built. The sequence loops until `stop`.
- Undefined: one burst per `start`, then IDLE. GAP logic and the gap register are removed and `gap_len` is unused.

## Structure
- Shared package `datagen_pkg`:
  - state encoding constants `ST_IDLE`, `ST_RUN`, `ST_GAP`;
  - default widths `DATAGEN_DATA_W`, `DATAGEN_LEN_W`, `DATAGEN_GAP_W`.
- Sub-module `pattern_cnt`: DATA_W wrapping counter with synchronous `load`/`load_val` and `en`, async active-low reset to 0. The controller drives `en` = transfer.

## Test plan
- Async reset: pull `rst` low at word 3 of an 8-word burst -> all outputs 0 immediately; after release, stays IDLE until a new `start`.
- Wrap: seed=60, len=8, `out_ready`=1 -> data 60,61,62,63,0,1,2,3 on consecutive cycles; `out_last` on 3; `done` one cycle later.
- Backpressure: seed=0, len=4, `out_ready` = 1,0,1,0,… -> data holds while ready=0; exactly 0,1,2,3 transferred in 8 cycles.
- Invalid length: `burst_len`=0 with `start` -> `busy` stays 0, no valid. `start`+`stop` together in IDLE -> no burst.
- Repeat (REPEAT_EN): seed=5, len=3, gap=2 -> 5,6,7, 2 idle cycles, 5,6,7, …
  - `stop` mid second burst -> that burst finishes, `done` pulses, IDLE.
  - `stop` in GAP -> IDLE, no `done`.
- Ignored start: pulse `start` with new seed=9 during RUN (seed=1, len=4) -> output stays 1,2,3,4; the new seed is used only at the next IDLE start.
